ieee_host_ctrl: RTL and testbench
=================================

# ieee_host_ctrl

IEEE-488 controller-side handshake engine for the CBM-II host. It sources command and data bytes (talk) and accepts data bytes (listen) over the three-wire DAV/NRFD/NDAC handshake. It sits between the host's I/O glue and the shared `st_ieee_bus` wired-AND bus that the 4040/8250 drive models hang on. All bus signals are active-low, and 1 means released.

## Interface
- `T_SETTLE`, default 2: data-settle delay in `ce` ticks, from driving data to asserting DAV, and from asserting ATN to the first handshake check.
- `TIMEOUT`, default 65535: handshake watchdog limit in `ce` ticks. Used only with `IEEE_HOST_TIMEOUT_EN`.

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `ce`  in  1  1 MHz bus-phase enable. All state advances only on `ce`.
- `cmd_valid`  in  1  request strobe. Held until accepted.
- `cmd_ready`  out  1  engine idle; a request is accepted when `cmd_valid & cmd_ready & ce`.
- `cmd_dir`  in  1  0 = source (talk) a byte, 1 = accept (listen) a byte.
- `cmd_atn`  in  1  1 = the byte is a command (ATN low). Ignored when `cmd_dir=1`.
- `cmd_eoi`  in  1  assert EOI with this byte (talk only).
- `cmd_data`  in  8  byte to source.
- `rsp_valid`  out  1  one-`ce`-tick pulse when a transfer ends.
- `rsp_data`  out  8  received byte (listen). Holds the sent byte on talk.
- `rsp_eoi`  out  1  EOI was sampled low with the received byte.
- `rsp_err`  out  2  00 = OK, 01 = device not present, 10 = timeout.
- `bus_i`  in  `st_ieee_bus`  resolved bus.
- `bus_o`  out  `st_ieee_bus`  this node's drive.

## Operation
- `bus_o.data` is `~byte` while sourcing and `8'hFF` otherwise.
- `bus_o.srq`, `bus_o.ren` and `bus_o.ifc` are always 1.
- ATN is latched on accept: `atn_q <= cmd_atn & ~cmd_dir`, and `bus_o.atn = ~atn_q`.
  - ATN stays asserted after a command byte completes. This lets consecutive command bytes keep ATN low.
  - ATN changes only at the next accept.
- **IDLE**
  - `cmd_ready=1`. NRFD and NDAC are released, DAV and EOI are released, data is `FF`.
  - On accept, go to `T_SET` for talk or `L_RFD` for listen.
- Talk path:
  - **T_SET**: wait `T_SETTLE` ticks with data driven. Then check the bus.
    - If `bus_i.nrfd=1 & bus_i.ndac=1`, no acceptor is present: set `rsp_err=01` and go to `DONE`.
    - Otherwise go to `T_RFD`.
  - **T_RFD**: wait for `bus_i.nrfd=1`. Then drive EOI with `cmd_eoi` and assert DAV=0. Go to `T_DAC`.
  - **T_DAC**: wait for `bus_i.ndac=1`. Then release DAV, EOI and data. Go to `DONE`.
- Listen path (ATN forced released):
  - **L_RFD**: hold NDAC=0 and release NRFD=1. Wait for `bus_i.dav=0`.
    - On DAV low, latch `rsp_data = ~bus_i.data` and `rsp_eoi = ~bus_i.eoi`.
    - Assert NRFD=0 and go to `L_DAC`.
  - **L_DAC**: release NDAC=1. Wait for `bus_i.dav=1`, then assert NDAC=0. Go to `DONE`.
- **DONE**: pulse `rsp_valid` for one tick and return to `IDLE`. `rsp_*` holds until the next `DONE`.
- Simultaneous events: a bus condition already true on the tick of state entry is taken on that same tick. DAV high and DAV low sampled in consecutive ticks are each honoured in order.
- Reset mid-transfer:
  - Aborts immediately. All bus lines are released, `atn_q=0`, state goes to `IDLE`.
  - No `rsp_valid` is generated.

## Timing
- Reset values: every `bus_o` field is 1, `cmd_ready=0` during reset and 1 on the first cycle after, `rsp_valid=0`, `rsp_data=00`, `rsp_eoi=0`, `rsp_err=00`.
- Talk with an immediately responding device: accept → DAV low in `T_SETTLE+1` ticks. `rsp_valid` rises 1 tick after NDAC is sampled released.
- Listen: `rsp_valid` rises 2 ticks after DAV is sampled high.
- Bus inputs are used registered, with one `clk_sys` stage. They are sampled only on `ce`.

## Configuration
- `IEEE_HOST_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every state change and counts `ce` ticks in `T_RFD`, `T_DAC`, `L_RFD` and `L_DAC`.
  - Reaching `TIMEOUT` releases all lines except ATN, sets `rsp_err=10`, and goes to `DONE`.
- Undefined: no counter; wait states block indefinitely and `rsp_err[1]` is constant 0.

## Test plan
- Talk `cmd_atn=1`, `data=28`, device model handshaking → bus data shows `D7` while DAV is low, ATN stays low after `rsp_valid`, `rsp_err=00`.
- Talk with NRFD and NDAC both released (no device) → `rsp_err=01` after `T_SETTLE` ticks, DAV never asserted.
- Listen: device sources `41` with EOI low → `rsp_data=41`, `rsp_eoi=1`; NRFD and NDAC sequence as specified; ATN released.
- Two back-to-back ATN bytes `28` then `6F` → ATN is continuously low across both; one `rsp_valid` per byte.
- With `IEEE_HOST_TIMEOUT_EN` and `TIMEOUT=100`, NRFD held low forever → `rsp_err=10` at tick 100 and DAV released. Without the macro the engine stays in `T_RFD`.
- Reset asserted while in `T_DAC` → next cycle all `bus_o` fields are 1, no `rsp_valid` pulse, and `cmd_ready=1` after reset is released.

Source files
------------

// File: rtl/ieee_host_ctrl_pkg.sv
// Shared IEEE-488 bus type for the CBM-II host and drive models.
// All fields are active-low; 1 means released.
package ieee_host_ctrl_pkg;

   typedef struct packed {
      logic [7:0] data;
      logic       dav;
      logic       nrfd;
      logic       ndac;
      logic       eoi;
      logic       atn;
      logic       srq;
      logic       ren;
      logic       ifc;
   } st_ieee_bus;

endpackage

// File: rtl/ieee_host_ctrl.sv
// IEEE-488 controller handshake engine: talks (command/data) and listens over DAV/NRFD/NDAC.
// Define IEEE_HOST_TIMEOUT_EN to enable the handshake watchdog (TIMEOUT ce ticks).
module ieee_host_ctrl
   import ieee_host_ctrl_pkg::*;
#(
   parameter int unsigned T_SETTLE = 2,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_dir,
   input  logic       cmd_atn,
   input  logic       cmd_eoi,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_eoi,
   output logic [1:0] rsp_err,
   input  st_ieee_bus bus_i,
   output st_ieee_bus bus_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_T_SET = 3'd1;
   localparam logic [2:0] S_T_RFD = 3'd2;
   localparam logic [2:0] S_T_DAC = 3'd3;
   localparam logic [2:0] S_L_RFD = 3'd4;
   localparam logic [2:0] S_L_DAC = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   if (TIMEOUT == 0 || TIMEOUT > 65536) begin : g_bad_timeout
      $error("ieee_host_ctrl: TIMEOUT must be in 1..65536");
   end
   if (T_SETTLE > 65535) begin : g_bad_settle
      $error("ieee_host_ctrl: T_SETTLE must be below 65536");
   end

   logic [2:0]  state_q, state_d;
   logic        atn_q, src_q, dav_q, eoi_q, nrfd_q, ndac_q;
   logic [7:0]  tx_q;
   logic        tx_eoi_q;
   logic [15:0] set_cnt_q;
   logic [7:0]  work_data_q;
   logic        work_eoi_q;
   logic [1:0]  work_err_q;

   logic [7:0]  bus_data_q;
   logic        bus_dav_q, bus_nrfd_q, bus_ndac_q, bus_eoi_q;

   logic        accept, settle_done, to_hit, to_fire, in_wait;
   logic        unused_bus;

   assign unused_bus  = ^{bus_i.atn, bus_i.srq, bus_i.ren, bus_i.ifc};
   assign cmd_ready   = (state_q == S_IDLE) && !reset;
   assign accept      = cmd_valid && cmd_ready && ce;
   assign settle_done = (32'(set_cnt_q) + 32'd1) >= T_SETTLE;
   assign in_wait     = (state_q == S_T_RFD) || (state_q == S_T_DAC) ||
                        (state_q == S_L_RFD) || (state_q == S_L_DAC);

   // One clk_sys stage on the bus before any decision is made from it.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bus_data_q <= 8'hFF;
         bus_dav_q  <= 1'b1;
         bus_nrfd_q <= 1'b1;
         bus_ndac_q <= 1'b1;
         bus_eoi_q  <= 1'b1;
      end else begin
         bus_data_q <= bus_i.data;
         bus_dav_q  <= bus_i.dav;
         bus_nrfd_q <= bus_i.nrfd;
         bus_ndac_q <= bus_i.ndac;
         bus_eoi_q  <= bus_i.eoi;
      end
   end

`ifdef IEEE_HOST_TIMEOUT_EN
   logic [15:0] to_cnt_q;

   assign to_hit = (32'(to_cnt_q) + 32'd1) >= TIMEOUT;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else if (ce) begin
         if (state_d != state_q) begin
            to_cnt_q <= '0;
         end else if (in_wait) begin
            to_cnt_q <= to_cnt_q + 16'd1;
         end
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      to_fire = 1'b0;
      case (state_q)
         S_IDLE:  if (accept) state_d = cmd_dir ? S_L_RFD : S_T_SET;
         S_T_SET: if (settle_done) state_d = (bus_nrfd_q && bus_ndac_q) ? S_DONE : S_T_RFD;
         S_T_RFD: begin
            if (bus_nrfd_q) state_d = S_T_DAC;
            else if (to_hit) to_fire = 1'b1;
         end
         S_T_DAC: begin
            if (bus_ndac_q) state_d = S_DONE;
            else if (to_hit) to_fire = 1'b1;
         end
         S_L_RFD: begin
            if (!bus_dav_q) state_d = S_L_DAC;
            else if (to_hit) to_fire = 1'b1;
         end
         S_L_DAC: begin
            // NDAC is re-asserted on the DAV-high tick; DONE follows on the next tick.
            if (!ndac_q) state_d = S_DONE;
            else if (!bus_dav_q && to_hit) to_fire = 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (to_fire) state_d = S_DONE;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= S_IDLE;
         atn_q       <= 1'b0;
         src_q       <= 1'b0;
         dav_q       <= 1'b1;
         eoi_q       <= 1'b1;
         nrfd_q      <= 1'b1;
         ndac_q      <= 1'b1;
         tx_q        <= 8'h00;
         tx_eoi_q    <= 1'b0;
         set_cnt_q   <= '0;
         work_data_q <= 8'h00;
         work_eoi_q  <= 1'b0;
         work_err_q  <= 2'b00;
         rsp_valid   <= 1'b0;
         rsp_data    <= 8'h00;
         rsp_eoi     <= 1'b0;
         rsp_err     <= 2'b00;
      end else if (ce) begin
         state_q   <= state_d;
         rsp_valid <= 1'b0;
         case (state_q)
            S_IDLE: if (accept) begin
               atn_q       <= cmd_atn & ~cmd_dir;
               tx_q        <= cmd_data;
               tx_eoi_q    <= cmd_eoi;
               set_cnt_q   <= '0;
               work_data_q <= cmd_data;
               work_eoi_q  <= 1'b0;
               work_err_q  <= 2'b00;
               if (cmd_dir) begin
                  ndac_q <= 1'b0;
                  nrfd_q <= 1'b1;
               end else begin
                  src_q <= 1'b1;
               end
            end
            S_T_SET: begin
               set_cnt_q <= set_cnt_q + 16'd1;
               if (settle_done && bus_nrfd_q && bus_ndac_q) begin
                  work_err_q <= 2'b01;
                  src_q      <= 1'b0;
               end
            end
            S_T_RFD: if (bus_nrfd_q) begin
               dav_q <= 1'b0;
               eoi_q <= ~tx_eoi_q;
            end
            S_T_DAC: if (bus_ndac_q) begin
               dav_q <= 1'b1;
               eoi_q <= 1'b1;
               src_q <= 1'b0;
            end
            S_L_RFD: if (!bus_dav_q) begin
               work_data_q <= ~bus_data_q;
               work_eoi_q  <= ~bus_eoi_q;
               nrfd_q      <= 1'b0;
               ndac_q      <= 1'b1;
            end
            S_L_DAC: if (ndac_q && bus_dav_q) ndac_q <= 1'b0;
            S_DONE: begin
               rsp_valid <= 1'b1;
               rsp_data  <= work_data_q;
               rsp_eoi   <= work_eoi_q;
               rsp_err   <= work_err_q;
               nrfd_q    <= 1'b1;
               ndac_q    <= 1'b1;
            end
            default: ;
         endcase
         if (to_fire) begin
            dav_q      <= 1'b1;
            eoi_q      <= 1'b1;
            src_q      <= 1'b0;
            nrfd_q     <= 1'b1;
            ndac_q     <= 1'b1;
            work_err_q <= 2'b10;
         end
      end
   end

   always_comb begin
      bus_o      = '1;
      bus_o.data = src_q ? ~tx_q : 8'hFF;
      bus_o.dav  = dav_q;
      bus_o.nrfd = nrfd_q;
      bus_o.ndac = ndac_q;
      bus_o.eoi  = eoi_q;
      bus_o.atn  = ~atn_q;
   end

endmodule

// File: tb/tb_ieee_host_ctrl.sv
// Scoreboard bench for ieee_host_ctrl: directed talk/listen/no-device/stall/reset cases.
module tb_ieee_host_ctrl;
   import ieee_host_ctrl_pkg::*;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       ce = 1'b0;
   logic       cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_atn = 1'b0, cmd_eoi = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, rsp_valid, rsp_eoi;
   logic [7:0] rsp_data;
   logic [1:0] rsp_err;
   st_ieee_bus bus_i, bus_o, dev;

   typedef struct {
      logic [7:0] d;
      logic       e;
      logic [1:0] err;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   n_checks = 0;
   int   n_err = 0;
   int   ce_cnt = 0;
   logic rv_prev = 1'b0;
   logic atn_watch = 1'b0, atn_glitch = 1'b0;
   logic dav_watch = 1'b0, dav_seen = 1'b0;

   assign bus_i = bus_o & dev;

   ieee_host_ctrl #(.T_SETTLE(2), .TIMEOUT(100)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ce        (ce),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_atn   (cmd_atn),
      .cmd_eoi   (cmd_eoi),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_eoi   (rsp_eoi),
      .rsp_err   (rsp_err),
      .bus_i     (bus_i),
      .bus_o     (bus_o)
   );

   initial forever #5 clk_sys = ~clk_sys;

   // ce: one clk_sys cycle in three
   initial forever begin
      @(negedge clk_sys);
      ce = (ce_cnt == 2);
      ce_cnt = (ce_cnt + 1) % 3;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each rsp_valid pulse.
   initial forever begin
      @(negedge clk_sys);
      if (rsp_valid && !rv_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_data", {24'b0, rsp_data}, {24'b0, mon_e.d});
            check("rsp_eoi", {31'b0, rsp_eoi}, {31'b0, mon_e.e});
            check("rsp_err", {30'b0, rsp_err}, {30'b0, mon_e.err});
         end
      end
      rv_prev = rsp_valid;
      if (atn_watch && bus_o.atn) atn_glitch = 1'b1;
      if (dav_watch && !bus_o.dav) dav_seen = 1'b1;
   end

   task automatic tick();
      @(posedge clk_sys);
      while (!ce) @(posedge clk_sys);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic line(input int which);
      case (which)
         0:       return bus_o.dav;
         1:       return bus_o.nrfd;
         default: return bus_o.ndac;
      endcase
   endfunction

   task automatic wait_line(input string name, input int which, input logic val);
      for (int i = 0; i < 60 && line(which) !== val; i++) tick();
      check(name, {31'b0, line(which)}, {31'b0, val});
   endtask

   task automatic issue(input logic dir, input logic atn, input logic eoi, input logic [7:0] d);
      int   guard;
      logic ok;
      guard = 0;
      @(negedge clk_sys);
      cmd_dir   = dir;
      cmd_atn   = atn;
      cmd_eoi   = eoi;
      cmd_data  = d;
      cmd_valid = 1'b1;
      do begin
         @(posedge clk_sys);
         guard++;
      end while (!(ce && cmd_ready) && guard < 300);
      ok = ce && cmd_ready;
      #1;
      cmd_valid = 1'b0;
      check("accept", {31'b0, ok}, 32'd1);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      ticks(2);
      check(name, exp_q.size(), 32'd0);
   endtask

   // Acceptor side of one talk byte, as a drive model would do it.
   task automatic dev_listen(input string name, input logic [7:0] bus_data);
      wait_line({name, "_dav_low"}, 0, 1'b0);
      check({name, "_bus_data"}, {24'b0, bus_i.data}, {24'b0, bus_data});
      dev.nrfd = 1'b0;
      dev.ndac = 1'b1;
      wait_line({name, "_dav_high"}, 0, 1'b1);
      dev.ndac = 1'b0;
      dev.nrfd = 1'b1;
   endtask

   initial begin
      dev = '1;
      // Reset values
      repeat (4) @(negedge clk_sys);
      check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("reset_bus_o", {16'b0, bus_o}, 32'h0000_FFFF);
      @(negedge clk_sys);
      reset = 1'b0;
      @(posedge clk_sys);
      #1;
      check("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("post_reset_rsp", {20'b0, rsp_valid, rsp_data, rsp_eoi, rsp_err}, 32'd0);

      // Talk ATN byte 28 with a responsive listener, cycle by cycle
      dev.ndac = 1'b0;
      dev.nrfd = 1'b1;
      exp_q.push_back('{d: 8'h28, e: 1'b0, err: 2'b00});
      issue(1'b0, 1'b1, 1'b0, 8'h28);
      tick();
      check("t1_dav_tick1", {31'b0, bus_o.dav}, 32'd1);
      tick();
      check("t1_dav_tick2", {31'b0, bus_o.dav}, 32'd1);
      tick();
      check("t1_dav_tick3", {31'b0, bus_o.dav}, 32'd0);
      check("t1_bus_data", {24'b0, bus_i.data}, 32'hD7);
      check("t1_atn_low", {31'b0, bus_o.atn}, 32'd0);
      dev.nrfd = 1'b0;
      dev.ndac = 1'b1;
      tick();
      check("t1_dav_release", {31'b0, bus_o.dav}, 32'd1);
      check("t1_data_release", {24'b0, bus_o.data}, 32'hFF);
      check("t1_rsp_not_yet", {31'b0, rsp_valid}, 32'd0);
      tick();
      check("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      dev.ndac = 1'b0;
      dev.nrfd = 1'b1;
      tick();
      check("t1_atn_held", {31'b0, bus_o.atn}, 32'd0);
      wait_drain("t1_drain");

      // Back-to-back ATN bytes 28, 6F: ATN never released
      atn_watch = 1'b1;
      exp_q.push_back('{d: 8'h28, e: 1'b0, err: 2'b00});
      issue(1'b0, 1'b1, 1'b0, 8'h28);
      dev_listen("b2b_a", 8'hD7);
      exp_q.push_back('{d: 8'h6F, e: 1'b0, err: 2'b00});
      issue(1'b0, 1'b1, 1'b1, 8'h6F);
      wait_line("b2b_b_dav_low", 0, 1'b0);
      check("b2b_b_eoi", {31'b0, bus_o.eoi}, 32'd0);
      check("b2b_b_bus_data", {24'b0, bus_i.data}, 32'h90);
      dev.nrfd = 1'b0;
      dev.ndac = 1'b1;
      wait_line("b2b_b_dav_high", 0, 1'b1);
      dev.ndac = 1'b0;
      dev.nrfd = 1'b1;
      wait_drain("b2b_drain");
      atn_watch = 1'b0;
      check("b2b_atn_continuous", {31'b0, atn_glitch}, 32'd0);

      // No device present: NRFD and NDAC both released
      dev = '1;
      dav_watch = 1'b1;
      exp_q.push_back('{d: 8'h55, e: 1'b0, err: 2'b01});
      issue(1'b0, 1'b0, 1'b0, 8'h55);
      ticks(2);
      check("nodev_rsp_early", {31'b0, rsp_valid}, 32'd0);
      tick();
      check("nodev_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("nodev_atn_released", {31'b0, bus_o.atn}, 32'd1);
      wait_drain("nodev_drain");
      dav_watch = 1'b0;
      check("nodev_dav_never", {31'b0, dav_seen}, 32'd0);

      // Listen: device sources 41 with EOI
      exp_q.push_back('{d: 8'h41, e: 1'b1, err: 2'b00});
      issue(1'b1, 1'b1, 1'b0, 8'h00);
      check("l_ndac_held", {31'b0, bus_o.ndac}, 32'd0);
      check("l_nrfd_released", {31'b0, bus_o.nrfd}, 32'd1);
      check("l_atn_released", {31'b0, bus_o.atn}, 32'd1);
      dev.data = 8'hBE;
      dev.eoi  = 1'b0;
      dev.dav  = 1'b0;
      wait_line("l_nrfd_low", 1, 1'b0);
      check("l_ndac_released", {31'b0, bus_o.ndac}, 32'd1);
      dev.dav  = 1'b1;
      dev.eoi  = 1'b1;
      dev.data = 8'hFF;
      wait_line("l_ndac_low", 2, 1'b0);
      tick();
      check("l_rsp_not_yet", {31'b0, rsp_valid}, 32'd0);
      tick();
      check("l_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("l_lines_idle", {30'b0, bus_o.nrfd, bus_o.ndac}, 32'd3);
      wait_drain("l_drain");

      // Listener present but never ready: NRFD held low
      dev.ndac = 1'b0;
      dev.nrfd = 1'b0;
`ifdef IEEE_HOST_TIMEOUT_EN
      exp_q.push_back('{d: 8'h11, e: 1'b0, err: 2'b10});
      issue(1'b0, 1'b0, 1'b0, 8'h11);
      wait_drain("to_drain");
      check("to_dav_released", {31'b0, bus_o.dav}, 32'd1);
      check("to_data_released", {24'b0, bus_o.data}, 32'hFF);
`else
      issue(1'b0, 1'b0, 1'b0, 8'h11);
      ticks(120);
      check("stall_dav_high", {31'b0, bus_o.dav}, 32'd1);
      check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("stall_data_driven", {24'b0, bus_o.data}, 32'hEE);
      @(negedge clk_sys);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      @(posedge clk_sys);
      #1;
      check("stall_recover_ready", {31'b0, cmd_ready}, 32'd1);
`endif

      // Reset while in T_DAC
      dev.ndac = 1'b0;
      dev.nrfd = 1'b1;
      issue(1'b0, 1'b1, 1'b1, 8'h3C);
      wait_line("rst_dav_low", 0, 1'b0);
      dev.nrfd = 1'b0;
      tick();
      check("rst_in_tdac", {31'b0, bus_o.dav}, 32'd0);
      @(negedge clk_sys);
      reset = 1'b1;
      @(posedge clk_sys);
      #1;
      check("rst_bus_o_released", {16'b0, bus_o}, 32'h0000_FFFF);
      check("rst_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk_sys);
      reset = 1'b0;
      dev = '1;
      @(posedge clk_sys);
      #1;
      check("rst_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
      ticks(10);
      check("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
